seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 135 +++++++++++++
 tb/tb_seq_multiplier.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one partial product per clock.
//
// A request is accepted in IDLE when start is high. The operands and the mode
// are captured, WIDTH shift-add steps run in CALC, and FINISH writes the result.
// Start-to-done latency is always WIDTH+1 edges. A start that arrives while the
// block is busy is dropped.
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-high reset
//   start       request a multiply (accepted only in IDLE)
//   signed_mode 0 = unsigned operands, 1 = two's-complement operands
//   a, b        multiplicand / multiplier, WIDTH bits
//   busy        high while an operation is in progress
//   done        one-cycle pulse when product has been updated
//   product     2*WIDTH-bit result, held until the next completion
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;

  logic [PW-1:0]    acc;
  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;
  logic             neg_result;

  logic             capture_c;
  logic             step_c;
  logic             finish_c;
  logic             last_step_c;

  // Magnitude of a WIDTH-bit operand; the most negative value maps to
  // 2^(WIDTH-1), which still fits in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             neg);
    return neg ? (~v + WIDTH'(1)) : v;
  endfunction

  assign last_step_c = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_step_c) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath control strobes decoded from the current state
  always_comb begin
    capture_c = 1'b0;
    step_c    = 1'b0;
    finish_c  = 1'b0;
    case (state)
      IDLE:    capture_c = start;
      CALC:    step_c    = 1'b1;
      FINISH:  finish_c  = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      mcand      <= '0;
      mplier     <= '0;
      cnt        <= '0;
      neg_result <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      product    <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= finish_c;

      if (capture_c) begin
        mcand      <= {{WIDTH{1'b0}}, magnitude(a, signed_mode & a[WIDTH-1])};
        mplier     <= magnitude(b, signed_mode & b[WIDTH-1]);
        acc        <= '0;
        cnt        <= '0;
        neg_result <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
      end

      // One partial product per cycle; multiplier consumed LSB first
      if (step_c) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
      end

      if (finish_c) begin
        product <= neg_result ? (~acc + PW'(1)) : acc;
      end
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed testbench for seq_multiplier: WIDTH=4 and WIDTH=8 instances on one clock.
module tb_seq_multiplier;

  logic        clk = 1'b0;
  logic        reset;

  logic        start4, sm4;
  logic [3:0]  a4, b4;
  logic        busy4, done4;
  logic [7:0]  prod4;

  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] prod8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4),
    .a(a4), .b(b4), .busy(busy4), .done(done4), .product(prod4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
    .a(a8), .b(b8), .busy(busy8), .done(done8), .product(prod8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a WIDTH=4 multiply at the next edge; lat = edges from E0 to done
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                     output int lat);
    a4 = a; b4 = b; sm4 = sm; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    lat = 0;
    while (!done4 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                     output int lat);
    a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 30) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    int gap;

    reset = 1'b1;
    start4 = 1'b0; sm4 = 1'b0; a4 = '0; b4 = '0;
    start8 = 1'b0; sm8 = 1'b0; a8 = '0; b8 = '0;
    tick();
    tick();
    check("rst_busy4", busy4, 0);
    check("rst_done4", done4, 0);
    check("rst_prod4", prod4, 0);
    check("rst_prod8", prod8, 0);

    // 15*15 unsigned, start in the first edge after reset release
    reset = 1'b0;
    a4 = 4'd15; b4 = 4'd15; sm4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    check("ff_busy_e0", busy4, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("ff_busy_calc", busy4, 1);
      check("ff_done_calc", done4, 0);
      check("ff_prod_hold", prod4, 0);
    end
    tick();
    check("ff_busy_e5", busy4, 0);
    check("ff_done_e5", done4, 1);
    check("ff_prod", prod4, 8'hE1);
    tick();
    check("ff_done_after", done4, 0);
    check("ff_prod_held", prod4, 8'hE1);

    // Signed cases
    op4(4'b1101, 4'd5, 1'b1, lat);
    check("s_m3x5_lat", lat, 5);
    check("s_m3x5", prod4, 8'hF1);
    tick();
    op4(4'b1000, 4'b1000, 1'b1, lat);
    check("s_m8xm8_lat", lat, 5);
    check("s_m8xm8", prod4, 8'h40);
    tick();
    op4(4'b1000, 4'b1000, 1'b0, lat);
    check("u_8x8", prod4, 8'h40);
    tick();
    op4(4'd7, 4'b1110, 1'b1, lat);
    check("s_7xm2", prod4, 8'hF2);
    tick();

    // Re-pulsed start while busy must be ignored
    a4 = 4'd7; b4 = 4'd3; sm4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    a4 = 4'd2; b4 = 4'd2; sm4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    pulses = 0;
    for (int i = 3; i <= 14; i++) begin
      tick();
      if (done4) begin
        pulses++;
        if (pulses == 1) begin
          check("ign_lat", i, 5);
          check("ign_prod", prod4, 8'd21);
        end
      end
    end
    check("ign_pulses", pulses, 1);
    check("ign_prod_held", prod4, 8'd21);

    // Reset in the middle of an operation, then restart immediately
    a4 = 4'd9; b4 = 4'd9; sm4 = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("rst_mid_busy", busy4, 0);
    check("rst_mid_done", done4, 0);
    check("rst_mid_prod", prod4, 0);
    reset = 1'b0;
    op4(4'd2, 4'd3, 1'b0, lat);
    check("rst_restart_lat", lat, 5);
    check("rst_restart_prod", prod4, 8'd6);
    tick();

    // start held high: back-to-back operations, second with a zero operand
    a4 = 4'd5; b4 = 4'd6; sm4 = 1'b0; start4 = 1'b1;
    tick();
    lat = 0;
    while (!done4 && lat < 20) begin
      tick();
      lat++;
    end
    check("b2b_lat1", lat, 5);
    check("b2b_prod1", prod4, 8'd30);
    a4 = 4'd0; b4 = 4'd11;
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!done4 && gap < 20);
    start4 = 1'b0;
    check("b2b_gap", gap, 6);
    check("b2b_prod2", prod4, 8'd0);
    tick();
    check("b2b_done_low", done4, 0);
    tick();
    check("b2b_idle", busy4, 0);

    // WIDTH=8 instance
    op8(8'd255, 8'd255, 1'b0, lat);
    check("w8_ff_lat", lat, 9);
    check("w8_ff", prod8, 16'hFE01);
    tick();
    op8(8'h80, 8'h7F, 1'b1, lat);
    check("w8_s_lat", lat, 9);
    check("w8_s", prod8, 16'hC080);
    tick();
    op8(8'h80, 8'h80, 1'b1, lat);
    check("w8_mm", prod8, 16'h4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
